// File: rtl/iob_cycle_ctl_if.sv
// Fast-side request/response and slow IO-bus signals of the IOB cycle controller.
// The slave modport is the controller; the master modport is its environment.
interface iob_cycle_ctl_if;
    logic        BACT;
    logic        IOCS;
    logic        IOPWCS;
    logic        IACS;
    logic [23:1] A;
    logic        nWE;
    logic        nUDS;
    logic        nLDS;
    logic [15:0] DI;
    logic        IOACK;
    logic        IOBERR;
    logic [15:0] IORDD;
    logic        PWFULL;
    logic        PWERR;
    logic [23:1] IOB_A;
    logic [15:0] IOB_DO;
    logic        IOB_nAS;
    logic        IOB_nWE;
    logic        IOB_nUDS;
    logic        IOB_nLDS;
    logic        IOB_IACK;
    logic        IOB_nDTACK;
    logic [15:0] IOB_DI;

    modport slave (
        input  BACT, IOCS, IOPWCS, IACS, A, nWE, nUDS, nLDS, DI, IOB_nDTACK, IOB_DI,
        output IOACK, IOBERR, IORDD, PWFULL, PWERR,
        output IOB_A, IOB_DO, IOB_nAS, IOB_nWE, IOB_nUDS, IOB_nLDS, IOB_IACK
    );

    modport master (
        output BACT, IOCS, IOPWCS, IACS, A, nWE, nUDS, nLDS, DI, IOB_nDTACK, IOB_DI,
        input  IOACK, IOBERR, IORDD, PWFULL, PWERR,
        input  IOB_A, IOB_DO, IOB_nAS, IOB_nWE, IOB_nUDS, IOB_nLDS, IOB_IACK
    );
endinterface

// File: rtl/iob_cycle_ctl.sv
// Runs fast-side IO cycles as 68000-style nAS/nDTACK cycles on the slow IOB,
// with a one-entry posted-write buffer that is acknowledged at once and drained in background.
//
// state   | meaning
// IDLE    | no slow cycle; starts buffered posted write first, else a new request
// AS      | drive address/data/strobes, assert nAS
// WAIT    | wait for nDTACK, count toward timeout
// END_OK  | release nAS, deliver read data / ack or free buffer
// END_ERR | release nAS, deliver bus error / ack or PWERR pulse
// REC     | nAS held high for RECOVERY cycles
module iob_cycle_ctl #(
    parameter int TIMEOUT  = 255,
    parameter int RECOVERY = 2
) (
    input  logic           CLK,
    input  logic           RES,
    iob_cycle_ctl_if.slave bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int REC_W = (RECOVERY > 1) ? $clog2(RECOVERY) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_AS, S_WAIT, S_END_OK, S_END_ERR, S_REC
    } state_t;

    state_t state, state_nxt;

    logic        taken, cyc_live, cyc_posted, cyc_nwe, cyc_iack, cyc_nuds, cyc_nlds;
    logic [23:1] cyc_a, pw_a;
    logic [15:0] cyc_d, pw_d;
    logic        pw_nuds, pw_nlds, pw_full;
    logic        ioack, ioberr, pwerr;
    logic [15:0] iordd;
    logic        iob_nas, iob_nwe, iob_nuds, iob_nlds, iob_iack;
    logic [CNT_W-1:0] wait_cnt;
    logic [REC_W-1:0] rec_cnt;
    logic        request, posted_elig, pw_accept, np_accept, start, tmo, rec_done, ack_ok;

    always_comb begin
        request     = bus.BACT & bus.IOCS & ~taken;
        posted_elig = bus.IOPWCS & ~bus.nWE & ~bus.IACS;
        pw_accept   = request & posted_elig & ~pw_full;
        // a pending posted write always drains before any new non-posted cycle
        np_accept   = request & ~posted_elig & (state == S_IDLE) & ~pw_full;
        start       = (state == S_IDLE) & (pw_full | pw_accept | np_accept);
        tmo         = (wait_cnt == CNT_W'(TIMEOUT));
        rec_done    = (rec_cnt == '0);
        ack_ok      = cyc_live & bus.BACT;
        state_nxt   = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_AS;
            S_AS:      state_nxt = S_WAIT;
            S_WAIT: begin
                if (!bus.IOB_nDTACK) state_nxt = S_END_OK;
                else if (tmo)        state_nxt = S_END_ERR;
            end
            S_END_OK,
            S_END_ERR: state_nxt = S_REC;
            S_REC:     if (rec_done) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RES) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            taken      <= 1'b0;
            cyc_live   <= 1'b0;
            cyc_posted <= 1'b0;
            cyc_nwe    <= 1'b1;
            cyc_iack   <= 1'b0;
            cyc_nuds   <= 1'b1;
            cyc_nlds   <= 1'b1;
            cyc_a      <= '0;
            cyc_d      <= '0;
            pw_a       <= '0;
            pw_d       <= '0;
            pw_nuds    <= 1'b1;
            pw_nlds    <= 1'b1;
            pw_full    <= 1'b0;
            ioack      <= 1'b0;
            ioberr     <= 1'b0;
            pwerr      <= 1'b0;
            iordd      <= '0;
            iob_nas    <= 1'b1;
            iob_nwe    <= 1'b1;
            iob_nuds   <= 1'b1;
            iob_nlds   <= 1'b1;
            iob_iack   <= 1'b0;
            wait_cnt   <= '0;
            rec_cnt    <= '0;
        end else begin
            pwerr <= 1'b0;
            if (!bus.BACT) begin
                taken    <= 1'b0;
                cyc_live <= 1'b0;
                ioack    <= 1'b0;
                ioberr   <= 1'b0;
            end
            if (pw_accept | np_accept) taken <= 1'b1;
            if (np_accept) cyc_live <= 1'b1;
            if (pw_accept) begin
                pw_full <= 1'b1;
                pw_a    <= bus.A;
                pw_d    <= bus.DI;
                pw_nuds <= bus.nUDS;
                pw_nlds <= bus.nLDS;
                ioack   <= 1'b1;
            end
            if (start) begin
                cyc_posted <= pw_full | pw_accept;
                if (pw_full) begin
                    cyc_a    <= pw_a;
                    cyc_d    <= pw_d;
                    cyc_nwe  <= 1'b0;
                    cyc_nuds <= pw_nuds;
                    cyc_nlds <= pw_nlds;
                    cyc_iack <= 1'b0;
                end else begin
                    cyc_a    <= bus.A;
                    cyc_d    <= bus.DI;
                    cyc_nwe  <= bus.nWE;
                    cyc_nuds <= bus.nUDS;
                    cyc_nlds <= bus.nLDS;
                    cyc_iack <= np_accept & bus.IACS;
                end
            end
            case (state)
                S_AS: begin
                    iob_nas  <= 1'b0;
                    iob_nwe  <= cyc_nwe;
                    iob_nuds <= cyc_nuds;
                    iob_nlds <= cyc_nlds;
                    iob_iack <= cyc_iack;
                    wait_cnt <= '0;
                end
                S_WAIT: if (wait_cnt != {CNT_W{1'b1}}) wait_cnt <= wait_cnt + 1'b1;
                S_END_OK, S_END_ERR: begin
                    iob_nas  <= 1'b1;
                    iob_nwe  <= 1'b1;
                    iob_nuds <= 1'b1;
                    iob_nlds <= 1'b1;
                    iob_iack <= 1'b0;
                    rec_cnt  <= REC_W'(RECOVERY - 1);
                    if (cyc_posted) begin
                        pw_full <= 1'b0;
                        if (state == S_END_ERR) pwerr <= 1'b1;
                    end else if (ack_ok) begin
                        // an aborted fast cycle gets no ack and its read data is dropped
                        ioack <= 1'b1;
                        if (state == S_END_ERR) ioberr <= 1'b1;
                        else if (cyc_nwe)       iordd  <= bus.IOB_DI;
                    end
                end
                S_REC: if (!rec_done) rec_cnt <= rec_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.IOACK    = ioack;
    assign bus.IOBERR   = ioberr;
    assign bus.IORDD    = iordd;
    assign bus.PWFULL   = pw_full;
    assign bus.PWERR    = pwerr;
    assign bus.IOB_A    = cyc_a;
    assign bus.IOB_DO   = cyc_d;
    assign bus.IOB_nAS  = iob_nas;
    assign bus.IOB_nWE  = iob_nwe;
    assign bus.IOB_nUDS = iob_nuds;
    assign bus.IOB_nLDS = iob_nlds;
    assign bus.IOB_IACK = iob_iack;

endmodule

// File: tb/tb_iob_cycle_ctl.sv
// Directed bench for iob_cycle_ctl: a slow-bus slave with programmable DTACK delay
// logs every slow cycle; each test task drives the fast side and checks inline.
module tb_iob_cycle_ctl;

    logic CLK = 1'b0;
    logic RES;
    iob_cycle_ctl_if bus();

    iob_cycle_ctl #(.TIMEOUT(255), .RECOVERY(2)) dut (.CLK(CLK), .RES(RES), .bus(bus));

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc_n = 0;
    int dly   = 1;   // cycles after nAS low before DTACK; -1 = never

    always @(posedge CLK) cyc_n++;

    int lowcnt = 0;
    logic [23:1] log_a[$];
    logic [15:0] log_d[$];
    logic        log_nwe[$];
    logic        log_iack[$];
    int          log_fall[$];
    int          log_rise[$];

    always @(negedge CLK) begin
        if (bus.IOB_nAS === 1'b0) begin
            lowcnt++;
            if (lowcnt == 1) begin
                log_a.push_back(bus.IOB_A);
                log_d.push_back(bus.IOB_DO);
                log_nwe.push_back(bus.IOB_nWE);
                log_iack.push_back(bus.IOB_IACK);
                log_fall.push_back(cyc_n);
            end
            bus.IOB_nDTACK = (dly >= 0 && lowcnt >= dly) ? 1'b0 : 1'b1;
        end else begin
            if (lowcnt > 0) log_rise.push_back(cyc_n);
            lowcnt = 0;
            bus.IOB_nDTACK = 1'b1;
        end
    end

    function automatic int fall_at(input int i);
        return (i < log_fall.size()) ? log_fall[i] : -1000;
    endfunction

    function automatic int rise_at(input int i);
        return (i < log_rise.size()) ? log_rise[i] : -1000;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic req(input logic [23:0] addr, input logic nwe, input logic pw, input logic [15:0] d);
        bus.BACT = 1'b1; bus.IOCS = 1'b1; bus.IOPWCS = pw; bus.IACS = 1'b0;
        bus.A = addr[23:1]; bus.nWE = nwe; bus.nUDS = 1'b0; bus.nLDS = 1'b0; bus.DI = d;
    endtask

    task automatic rel();
        bus.BACT = 1'b0; bus.IOCS = 1'b0; bus.IOPWCS = 1'b0; bus.IACS = 1'b0;
        bus.nWE = 1'b1; bus.nUDS = 1'b1; bus.nLDS = 1'b1;
    endtask

    task automatic settle();
        rel();
        repeat (8) tick();
    endtask

    // which: 0 = IOACK high, 1 = PWFULL low, 2 = PWERR high; at = -1 on expiry
    task automatic wait_for(input int which, input int lim, output int at);
        at = -1;
        for (int i = 0; i < lim; i++) begin
            tick();
            if ((which == 0 && bus.IOACK === 1'b1) || (which == 1 && bus.PWFULL === 1'b0) ||
                (which == 2 && bus.PWERR === 1'b1)) begin
                at = cyc_n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [8:0] st;
        RES = 1'b1; rel(); bus.A = '0; bus.DI = '0; bus.IOB_DI = '0;
        tick(); tick();
        st = {bus.IOB_nAS, bus.IOB_nWE, bus.IOB_nUDS, bus.IOB_nLDS, bus.IOB_IACK,
              bus.IOACK, bus.IOBERR, bus.PWFULL, bus.PWERR};
        n_cmp++; if (st !== 9'b1111_00000) begin n_mis++; $display("FAIL reset_ctrl got=%b exp=111100000", st); end
        n_cmp++; if (bus.IORDD !== 16'h0) begin n_mis++; $display("FAIL reset_iordd got=%h exp=0000", bus.IORDD); end
        RES = 1'b0;
        tick();
    endtask

    task automatic test_read();
        int base, at;
        base = log_fall.size(); dly = 5; bus.IOB_DI = 16'hA55A;
        req(24'hEFE1FE, 1'b1, 1'b0, 16'h0);
        wait_for(0, 40, at);
        n_cmp++; if (at < 0 || at - fall_at(base) != 6) begin n_mis++; $display("FAIL read_latency ack_at=%0d nas_fall=%0d exp_diff=6", at, fall_at(base)); end
        n_cmp++; if (bus.IORDD !== 16'hA55A || bus.IOBERR !== 1'b0) begin n_mis++; $display("FAIL read_data iordd=%h berr=%b exp=a55a/0", bus.IORDD, bus.IOBERR); end
        n_cmp++; if (log_a.size() <= base || log_a[base] !== 23'h77F0FF || log_nwe[base] !== 1'b1 || log_iack[base] !== 1'b0)
            begin n_mis++; $display("FAIL read_iob_addr got=%h exp=77f0ff nwe=1 iack=0", (log_a.size() > base) ? log_a[base] : 23'h0); end
        repeat (3) tick();
        n_cmp++; if (bus.IOACK !== 1'b1) begin n_mis++; $display("FAIL read_ack_hold got=%b exp=1", bus.IOACK); end
        rel(); tick();
        n_cmp++; if (bus.IOACK !== 1'b0 || bus.IORDD !== 16'hA55A) begin n_mis++; $display("FAIL read_ack_clear ack=%b iordd=%h exp=0/a55a", bus.IOACK, bus.IORDD); end
        settle();
    endtask

    task automatic test_min_latency_iack();
        int base, at;
        base = log_fall.size(); dly = 1; bus.IOB_DI = 16'h0019;
        req(24'hFFFFF4, 1'b1, 1'b0, 16'h0); bus.IACS = 1'b1;
        wait_for(0, 20, at);
        n_cmp++; if (at < 0 || at - fall_at(base) != 2) begin n_mis++; $display("FAIL min_latency ack_at=%0d nas_fall=%0d exp_diff=2", at, fall_at(base)); end
        n_cmp++; if (log_iack.size() <= base || log_iack[base] !== 1'b1 || bus.IORDD !== 16'h0019)
            begin n_mis++; $display("FAIL iack_cycle iordd=%h exp=0019 with IOB_IACK=1", bus.IORDD); end
        settle();
    endtask

    task automatic test_posted_write();
        int base, at;
        base = log_fall.size(); dly = 3;
        req(24'h3FA700, 1'b0, 1'b1, 16'h1234);
        tick();
        n_cmp++; if (bus.IOACK !== 1'b1 || bus.PWFULL !== 1'b1) begin n_mis++; $display("FAIL pw_ack ack=%b pwfull=%b exp=1/1", bus.IOACK, bus.PWFULL); end
        rel();
        wait_for(1, 40, at);
        n_cmp++; if (at < 0 || at - fall_at(base) != 4) begin n_mis++; $display("FAIL pw_drain clr_at=%0d nas_fall=%0d exp_diff=4", at, fall_at(base)); end
        n_cmp++; if (log_a.size() <= base || log_a[base] !== 23'h1FD380 || log_d[base] !== 16'h1234 || log_nwe[base] !== 1'b0)
            begin n_mis++; $display("FAIL pw_iob got_a=%h got_d=%h exp=1fd380/1234 nwe=0", (log_a.size() > base) ? log_a[base] : 23'h0, (log_d.size() > base) ? log_d[base] : 16'h0); end
        n_cmp++; if (bus.IOACK !== 1'b0) begin n_mis++; $display("FAIL pw_ack_clear got=%b exp=0", bus.IOACK); end
        settle();
    endtask

    task automatic test_write_then_read();
        int base, at;
        base = log_fall.size(); dly = 2; bus.IOB_DI = 16'h0F0F;
        req(24'h3FA702, 1'b0, 1'b1, 16'hBEEF);
        tick(); rel(); tick();
        req(24'h9FFFF8, 1'b1, 1'b0, 16'h0);
        wait_for(0, 60, at);
        n_cmp++; if (log_a.size() <= base + 1 || log_a[base] !== 23'h1FD381 || log_a[base+1] !== 23'h4FFFFC)
            begin n_mis++; $display("FAIL wr_rd_order entries=%0d exp first=1fd381 second=4ffffc", log_a.size() - base); end
        n_cmp++; if (fall_at(base + 1) - rise_at(base) != 4) begin n_mis++; $display("FAIL wr_rd_recovery rd_fall=%0d wr_rise=%0d exp_diff=4", fall_at(base + 1), rise_at(base)); end
        n_cmp++; if (at < 0 || at - fall_at(base + 1) != 3 || bus.IORDD !== 16'h0F0F)
            begin n_mis++; $display("FAIL wr_rd_ack ack_at=%0d iordd=%h exp_diff=3 exp=0f0f", at - fall_at(base + 1), bus.IORDD); end
        settle();
    endtask

    task automatic test_abort();
        int base;
        logic acked;
        base = log_fall.size(); dly = 3; bus.IOB_DI = 16'h7777; acked = 1'b0;
        req(24'h000100, 1'b1, 1'b0, 16'h0);
        tick(); tick(); rel();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.IOACK === 1'b1) acked = 1'b1;
        end
        n_cmp++; if (acked !== 1'b0 || log_rise.size() <= base) begin n_mis++; $display("FAIL abort acked=%b slow_done=%0d exp=0/1", acked, log_rise.size() > base); end
        n_cmp++; if (bus.IORDD !== 16'h0F0F) begin n_mis++; $display("FAIL abort_iordd got=%h exp=0f0f", bus.IORDD); end
        settle();
    endtask

    task automatic test_timeout();
        int base, at;
        base = log_fall.size(); dly = -1;
        req(24'h800000, 1'b1, 1'b0, 16'h0);
        wait_for(0, 300, at);
        n_cmp++; if (at < 0 || at - fall_at(base) != 257) begin n_mis++; $display("FAIL timeout_latency ack_at=%0d nas_fall=%0d exp_diff=257", at, fall_at(base)); end
        n_cmp++; if (bus.IOBERR !== 1'b1 || bus.IORDD !== 16'h0F0F) begin n_mis++; $display("FAIL timeout_berr berr=%b iordd=%h exp=1/0f0f", bus.IOBERR, bus.IORDD); end
        rel(); tick();
        n_cmp++; if (bus.IOBERR !== 1'b0 || bus.IOACK !== 1'b0) begin n_mis++; $display("FAIL timeout_clear berr=%b ack=%b exp=0/0", bus.IOBERR, bus.IOACK); end
        settle();
    endtask

    task automatic test_posted_timeout();
        int base, first, pulses;
        logic berr_seen;
        base = log_fall.size(); dly = -1; first = -1; pulses = 0; berr_seen = 1'b0;
        req(24'h3FA704, 1'b0, 1'b1, 16'h5555);
        tick(); rel();
        for (int i = 0; i < 300; i++) begin
            tick();
            if (bus.PWERR === 1'b1) begin
                pulses++;
                if (first < 0) first = cyc_n;
            end
            if (bus.IOBERR === 1'b1) berr_seen = 1'b1;
        end
        n_cmp++; if (pulses != 1 || first - fall_at(base) != 257) begin n_mis++; $display("FAIL pw_timeout pulses=%0d diff=%0d exp=1/257", pulses, first - fall_at(base)); end
        n_cmp++; if (berr_seen !== 1'b0 || bus.PWFULL !== 1'b0) begin n_mis++; $display("FAIL pw_timeout_flags berr_seen=%b pwfull=%b exp=0/0", berr_seen, bus.PWFULL); end
        settle();
    endtask

    task automatic test_back_to_back_posted();
        int base, at, at2;
        base = log_fall.size(); dly = 4;
        req(24'h3FA710, 1'b0, 1'b1, 16'hAAAA);
        tick(); rel(); tick();
        req(24'h3FA712, 1'b0, 1'b1, 16'h5555);
        wait_for(0, 60, at);
        n_cmp++; if (at < 0 || at - rise_at(base) != 1) begin n_mis++; $display("FAIL pw_stall ack_at=%0d w1_end=%0d exp_diff=1", at, rise_at(base)); end
        rel();
        wait_for(1, 60, at2);
        n_cmp++; if (at2 < 0 || log_a.size() <= base + 1 || log_a[base] !== 23'h1FD388 || log_d[base] !== 16'hAAAA ||
                     log_a[base+1] !== 23'h1FD389 || log_d[base+1] !== 16'h5555)
            begin n_mis++; $display("FAIL pw_b2b_order entries=%0d clr_at=%0d exp 1fd388/aaaa then 1fd389/5555", log_a.size() - base, at2); end
        settle();
    endtask

    task automatic test_reset_mid();
        dly = -1;
        req(24'h200000, 1'b1, 1'b0, 16'h0);
        repeat (6) tick();
        n_cmp++; if (bus.IOB_nAS !== 1'b0) begin n_mis++; $display("FAIL rst_mid_pre nas=%b exp=0", bus.IOB_nAS); end
        RES = 1'b1; rel();
        tick(); tick();
        n_cmp++; if ({bus.IOB_nAS, bus.PWFULL, bus.IOACK} !== 3'b100 || bus.IORDD !== 16'h0)
            begin n_mis++; $display("FAIL rst_mid nas=%b pwfull=%b ack=%b iordd=%h exp=1/0/0/0000", bus.IOB_nAS, bus.PWFULL, bus.IOACK, bus.IORDD); end
        RES = 1'b0;
        settle();
    endtask

    initial begin
        test_reset();
        test_read();
        test_min_latency_iack();
        test_posted_write();
        test_write_then_read();
        test_abort();
        test_timeout();
        test_posted_timeout();
        test_back_to_back_posted();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
